// File: rtl/sr04_multi_ranger.sv
// Round-robin controller for up to N_CH HC-SR04 ultrasonic rangers with a per-channel result bank.
// Optional macro SR04_NEAREST_EN adds nearest_cnt/nearest_ch (closest valid, enabled channel).
module sr04_multi_ranger #(
    parameter int N_CH           = 4,
    parameter int CNT_W          = 24,
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int GAP_CYCLES     = 500000,
    parameter int STARTUP_CYCLES = 50000,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [N_CH-1:0]       ch_mask,
    input  logic [N_CH-1:0]       echo_in,
    output logic [N_CH-1:0]       trig_out,
    output logic [N_CH*CNT_W-1:0] echo_cnt,
    output logic [N_CH-1:0]       echo_valid,
    output logic                  sample_stb,
    output logic [CH_W-1:0]       sample_ch,
    output logic                  sample_timeout,
`ifdef SR04_NEAREST_EN
    output logic [CNT_W-1:0]      nearest_cnt,
    output logic [CH_W-1:0]       nearest_ch,
`endif
    output logic                  busy
);

    localparam logic [31:0] STARTUP_LEN = 32'(STARTUP_CYCLES);
    localparam logic [31:0] TRIG_LEN    = 32'(TRIG_CYCLES);
    localparam logic [31:0] TIMEOUT_LEN = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0] GAP_LEN     = 32'(GAP_CYCLES);
    localparam logic [63:0] TIMEOUT_L64 = 64'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_SELECT,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_GAP
    } state_t;

    state_t           state_reg, state_next;
    logic [31:0]      timer_reg, timer_next, timer_inc;
    logic [CNT_W-1:0] meas_cnt_reg, meas_cnt_next, cnt_inc;
    logic [CH_W-1:0]  ch_reg, ch_next, pick_ch;
    logic [N_CH-1:0]  trig_reg, trig_next;
    logic [N_CH-1:0]  echo_meta_reg, echo_sync_reg, echo_prev_reg;
    logic [N_CH-1:0]  valid_reg;
    logic [CNT_W-1:0] bank_reg [N_CH];
    logic             stb_reg, stb_to_reg;
    logic [CH_W-1:0]  stb_ch_reg;
    logic             rec_en, rec_timeout;
    logic             echo_sel, echo_rise;

    assign timer_inc = timer_reg + 32'd1;
    assign cnt_inc   = (meas_cnt_reg == '1) ? meas_cnt_reg : meas_cnt_reg + CNT_W'(1);
    assign echo_sel  = echo_sync_reg[ch_reg];
    assign echo_rise = echo_sel & ~echo_prev_reg[ch_reg];

    // Next enabled channel strictly after the current one, wrapping; may return the same channel.
    always_comb begin
        int  idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        pick_ch = ch_reg;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(ch_reg) + k) % N_CH;
            if (!found && ch_mask[idx]) begin
                pick_ch = CH_W'(idx);
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        timer_next    = timer_inc;
        meas_cnt_next = meas_cnt_reg;
        ch_next       = ch_reg;
        trig_next     = trig_reg;
        rec_en        = 1'b0;
        rec_timeout   = 1'b0;
        case (state_reg)
            ST_STARTUP: begin
                if (timer_inc >= STARTUP_LEN) begin
                    state_next = ST_SELECT;
                    timer_next = '0;
                end
            end
            ST_SELECT: begin
                timer_next = '0;
                if (enable && (ch_mask != '0)) begin
                    ch_next            = pick_ch;
                    trig_next          = '0;
                    trig_next[pick_ch] = 1'b1;
                    state_next         = ST_TRIG;
                end
            end
            ST_TRIG: begin
                if (timer_inc >= TRIG_LEN) begin
                    trig_next  = '0;
                    timer_next = '0;
                    state_next = ST_WAIT_RISE;
                end
            end
            ST_WAIT_RISE: begin
                if (echo_rise) begin
                    meas_cnt_next = '0;
                    state_next    = ST_MEASURE;
                end else if (timer_inc >= TIMEOUT_LEN) begin
                    rec_en      = 1'b1;
                    rec_timeout = 1'b1;
                    timer_next  = '0;
                    state_next  = ST_GAP;
                end
            end
            ST_MEASURE: begin
                // The rising cycle itself is high, so cnt_inc is the total high-cycle count.
                if (!echo_sel) begin
                    rec_en     = 1'b1;
                    timer_next = '0;
                    state_next = ST_GAP;
                end else if (64'(cnt_inc) >= TIMEOUT_L64) begin
                    rec_en      = 1'b1;
                    rec_timeout = 1'b1;
                    timer_next  = '0;
                    state_next  = ST_GAP;
                end else begin
                    meas_cnt_next = cnt_inc;
                end
            end
            ST_GAP: begin
                if (timer_inc >= GAP_LEN) begin
                    timer_next = '0;
                    state_next = ST_SELECT;
                end
            end
            default: begin
                state_next = ST_STARTUP;
                timer_next = '0;
                trig_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_STARTUP;
            timer_reg    <= '0;
            meas_cnt_reg <= '0;
            ch_reg       <= CH_W'(N_CH - 1);
            trig_reg     <= '0;
            stb_reg      <= 1'b0;
            stb_ch_reg   <= '0;
            stb_to_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            meas_cnt_reg <= meas_cnt_next;
            ch_reg       <= ch_next;
            trig_reg     <= trig_next;
            stb_reg      <= rec_en;
            if (rec_en) begin
                stb_ch_reg <= ch_reg;
                stb_to_reg <= rec_timeout;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            always_ff @(posedge clk) begin
                if (reset) begin
                    echo_meta_reg[gi] <= 1'b0;
                    echo_sync_reg[gi] <= 1'b0;
                    echo_prev_reg[gi] <= 1'b0;
                    bank_reg[gi]      <= '0;
                    valid_reg[gi]     <= 1'b0;
                end else begin
                    echo_meta_reg[gi] <= echo_in[gi];
                    echo_sync_reg[gi] <= echo_meta_reg[gi];
                    echo_prev_reg[gi] <= echo_sync_reg[gi];
                    if (rec_en && (ch_reg == CH_W'(gi))) begin
                        bank_reg[gi]  <= rec_timeout ? '1 : cnt_inc;
                        valid_reg[gi] <= ~rec_timeout;
                    end
                end
            end
            assign echo_cnt[gi*CNT_W +: CNT_W] = bank_reg[gi];
        end
    endgenerate

`ifdef SR04_NEAREST_EN
    logic [CNT_W-1:0] near_cnt_reg, best_cnt;
    logic [CH_W-1:0]  near_ch_reg, best_ch;

    // Scan high-to-low with <= so equal counts resolve to the lowest index.
    always_comb begin
        best_cnt = '1;
        best_ch  = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (valid_reg[k] && ch_mask[k] && (bank_reg[k] <= best_cnt)) begin
                best_cnt = bank_reg[k];
                best_ch  = CH_W'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            near_cnt_reg <= '1;
            near_ch_reg  <= '0;
        end else if (stb_reg) begin
            near_cnt_reg <= best_cnt;
            near_ch_reg  <= best_ch;
        end
    end

    assign nearest_cnt = near_cnt_reg;
    assign nearest_ch  = near_ch_reg;
`endif

    assign trig_out       = trig_reg;
    assign echo_valid     = valid_reg;
    assign sample_stb     = stb_reg;
    assign sample_ch      = stb_ch_reg;
    assign sample_timeout = stb_to_reg;
    assign busy           = (state_reg == ST_TRIG) || (state_reg == ST_WAIT_RISE) ||
                            (state_reg == ST_MEASURE) || (state_reg == ST_GAP);

endmodule
